sti_pack_serializer: RTL and testbench

Parametrised serial-transmit and pixel-pack engine. Accepts one DW-bit word per handshake. Extends or truncates the word to a programmable length of PW·(pi_length+1) bits and shifts it out one bit per cycle on so_data. Each completed PW-bit group is written to pixel memory. When pi_end is seen, all remaining pixel addresses are padded with FILL and completion is flagged. It sits between the host word interface and the pixel RAM, as the general-width successor of the fixed 16-bit/8-bit STI/DAC block.

---
 rtl/sti_pack_serializer_if.sv | 34 +++
 rtl/sti_pack_serializer.sv | 215 +++++++++++++++++++++
 tb/tb_sti_pack_serializer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sti_pack_serializer_if.sv
// Host word / pixel RAM bundle for sti_pack_serializer.
// master = host side (drives words, observes serial + pixel writes),
// slave  = serializer side.
interface sti_pack_serializer_if #(
  parameter int DW = 16,
  parameter int PW = 8,
  parameter int LW = 2,
  parameter int AW = 8
) ();
  logic          load;
  logic [DW-1:0] pi_data;
  logic [LW-1:0] pi_length;
  logic          pi_fill;
  logic          pi_low;
  logic          pi_msb;
  logic          pi_end;
  logic          pi_ready;
  logic          so_data;
  logic          so_valid;
  logic          pixel_wr;
  logic [AW-1:0] pixel_addr;
  logic [PW-1:0] pixel_dataout;
  logic          pixel_finish;

  modport master (
    output load, pi_data, pi_length, pi_fill, pi_low, pi_msb, pi_end,
    input  pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish
  );

  modport slave (
    input  load, pi_data, pi_length, pi_fill, pi_low, pi_msb, pi_end,
    output pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish
  );
endinterface

// File: rtl/sti_pack_serializer.sv
// Serial-transmit and pixel-pack engine.
// A DW-bit word is resized to an L = PW*(pi_length+1) bit frame, shifted out
// one bit per cycle, and every completed PW-bit group is written to pixel RAM.
// An end-qualified frame is followed by FILL writes up to the top address.
// All outputs are registered; pi_ready is decoded from the state register.
module sti_pack_serializer #(
  parameter int            DW   = 16,
  parameter int            PW   = 8,
  parameter int            LW   = 2,
  parameter int            AW   = 8,
  parameter logic [PW-1:0] FILL = {PW{1'b0}}
) (
  input logic                  clk,
  input logic                  reset,
  sti_pack_serializer_if.slave bus
);

  localparam int FW = PW << LW;                // longest frame
  localparam int XW = (DW > FW) ? DW : FW;     // working width for resizing
  localparam int CW = $clog2(FW + 1);          // bit counter width
  localparam int GW = (PW > 1) ? $clog2(PW) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Resize the word to its frame and align it so the first bit to send sits
  // at FW-1 (MSB-first) or at bit 0 (LSB-first).
  function automatic logic [FW-1:0] build_frame(
    input logic [DW-1:0] data,
    input logic [LW-1:0] len,
    input logic          fill,
    input logic          low,
    input logic          msb
  );
    logic [XW-1:0] x;
    logic [FW-1:0] f;
    int            l;
    l = PW * (int'(len) + 1);
    x = XW'(data);
    if (l >= DW) begin
      x = fill ? (x << (l - DW)) : x;
    end else begin
      x = low ? (x >> (DW - l)) : (x & ((XW'(1'b1) << l) - XW'(1'b1)));
    end
    f = FW'(x);
    f = msb ? (f << (FW - l)) : f;
    return f;
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s, last_s;
  logic [GW-1:0] grp_r, grp_s;
  logic [FW-1:0] sr_r, sr_s, frame_s, src_s;
  logic [PW-1:0] acc_r, acc_s;
  logic [AW-1:0] ptr_r, ptr_s;
  logic [LW-1:0] len_r, len_s;
  logic          msb_r, msb_s, end_r, end_s;
  logic          emit_s, bit_s, msb_sel_s;
  logic          so_data_r, so_data_s;
  logic          so_valid_r, so_valid_s;
  logic          wr_r, wr_s;
  logic [AW-1:0] addr_r, addr_s;
  logic [PW-1:0] dout_r, dout_s;
  logic          finish_r, finish_s;

  assign last_s = CW'(PW * (int'(len_r) + 1) - 1);

  // Next-state, datapath and next-output decode for the frame/pad sequencer
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    grp_s      = grp_r;
    sr_s       = sr_r;
    acc_s      = acc_r;
    ptr_s      = ptr_r;
    len_s      = len_r;
    msb_s      = msb_r;
    end_s      = end_r;
    so_data_s  = 1'b0;
    so_valid_s = 1'b0;
    wr_s       = 1'b0;
    addr_s     = addr_r;
    dout_s     = {PW{1'b0}};
    finish_s   = 1'b0;
    emit_s     = 1'b0;
    bit_s      = 1'b0;
    msb_sel_s  = msb_r;
    src_s      = sr_r;
    frame_s    = build_frame(bus.pi_data, bus.pi_length, bus.pi_fill, bus.pi_low, bus.pi_msb);

    case (state_r)
      IDLE: begin
        if (bus.load) begin
          len_s     = bus.pi_length;
          msb_s     = bus.pi_msb;
          end_s     = bus.pi_end;
          msb_sel_s = bus.pi_msb;
          src_s     = frame_s;
          cnt_s     = {CW{1'b0}};
          grp_s     = {GW{1'b0}};
          emit_s    = 1'b1;
          state_s   = SHIFT;
        end else begin
          state_s   = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r != last_s) begin
          emit_s  = 1'b1;
          cnt_s   = cnt_r + CW'(1'b1);
          grp_s   = (grp_r == GW'(PW - 1)) ? {GW{1'b0}} : grp_r + GW'(1'b1);
        end else if (!end_r) begin
          state_s = IDLE;
        end else if (ptr_r == {AW{1'b0}}) begin
          // last frame write landed on the top address: nothing to pad
          state_s  = DONE;
          finish_s = 1'b1;
        end else begin
          state_s = PAD;
          wr_s    = 1'b1;
          addr_s  = ptr_r;
          dout_s  = FILL;
          ptr_s   = ptr_r + AW'(1'b1);
        end
      end
      PAD: begin
        if (ptr_r == {AW{1'b0}}) begin
          state_s  = DONE;
          finish_s = 1'b1;
        end else begin
          wr_s   = 1'b1;
          addr_s = ptr_r;
          dout_s = FILL;
          ptr_s  = ptr_r + AW'(1'b1);
        end
      end
      DONE: begin
        state_s  = DONE;
        finish_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Shared bit emission: present one frame bit and close a pixel group
    if (emit_s) begin
      bit_s      = msb_sel_s ? src_s[FW-1] : src_s[0];
      sr_s       = msb_sel_s ? (src_s << 1) : (src_s >> 1);
      acc_s      = PW'({acc_r, bit_s});
      so_valid_s = 1'b1;
      so_data_s  = bit_s;
      if (grp_s == GW'(PW - 1)) begin
        wr_s   = 1'b1;
        addr_s = ptr_r;
        dout_s = acc_s;
        ptr_s  = ptr_r + AW'(1'b1);
      end else begin
        dout_s = {PW{1'b0}};
      end
    end else begin
      bit_s = 1'b0;
    end
  end

  // State, datapath and output registers; reset aborts any frame or pad run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      grp_r      <= {GW{1'b0}};
      sr_r       <= {FW{1'b0}};
      acc_r      <= {PW{1'b0}};
      ptr_r      <= {AW{1'b0}};
      len_r      <= {LW{1'b0}};
      msb_r      <= 1'b0;
      end_r      <= 1'b0;
      so_data_r  <= 1'b0;
      so_valid_r <= 1'b0;
      wr_r       <= 1'b0;
      addr_r     <= {AW{1'b0}};
      dout_r     <= {PW{1'b0}};
      finish_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      grp_r      <= grp_s;
      sr_r       <= sr_s;
      acc_r      <= acc_s;
      ptr_r      <= ptr_s;
      len_r      <= len_s;
      msb_r      <= msb_s;
      end_r      <= end_s;
      so_data_r  <= so_data_s;
      so_valid_r <= so_valid_s;
      wr_r       <= wr_s;
      addr_r     <= addr_s;
      dout_r     <= dout_s;
      finish_r   <= finish_s;
    end
  end

  assign bus.pi_ready      = (state_r == IDLE);
  assign bus.so_data       = so_data_r;
  assign bus.so_valid      = so_valid_r;
  assign bus.pixel_wr      = wr_r;
  assign bus.pixel_addr    = addr_r;
  assign bus.pixel_dataout = dout_r;
  assign bus.pixel_finish  = finish_r;

endmodule

// File: tb/tb_sti_pack_serializer.sv
// Self-checking bench for sti_pack_serializer: a queue of expected per-cycle
// outputs is built from the frame rules and compared every cycle.
`timescale 1ns/1ps
module tb_sti_pack_serializer;
  localparam int DW = 16, PW = 8, LW = 2, AW = 8;
  localparam logic [7:0] FILL_V = 8'hC3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sti_pack_serializer_if #(.DW(DW), .PW(PW), .LW(LW), .AW(AW)) bus ();

  sti_pack_serializer #(.DW(DW), .PW(PW), .LW(LW), .AW(AW), .FILL(FILL_V)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { bit v; bit d; bit wr; int addr; logic [7:0] dat; } rec_t;
  rec_t        exp_q[$];
  logic [15:0] wlog[$];   // {addr, data} of every observed pixel write
  int          m_ptr;
  bit          m_done;
  bit          noise_en;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame bit i (bit 0 = LSB of the L-bit frame)
  function automatic bit frame_bit(input logic [15:0] d, input int len, input bit fill,
                                   input bit low, input int i);
    int l = 8 * (len + 1);
    if (l >= DW) begin
      if (fill) return (i >= l - DW) ? d[i - (l - DW)] : 1'b0;
      else      return (i < DW) ? d[i] : 1'b0;
    end else begin
      if (low) return d[i + DW - l];
      else     return d[i];
    end
  endfunction

  // k-th bit on the wire
  function automatic bit sent_bit(input logic [15:0] d, input int len, input bit fill,
                                  input bit low, input bit msb, input int k);
    int l = 8 * (len + 1);
    return frame_bit(d, len, fill, low, msb ? (l - 1 - k) : k);
  endfunction

  // Pixel g: first-sent bit lands in bit 7
  function automatic logic [7:0] group_val(input logic [15:0] d, input int len, input bit fill,
                                           input bit low, input bit msb, input int g);
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[7 - j] = sent_bit(d, len, fill, low, msb, g * 8 + j);
    return v;
  endfunction

  task automatic push_frame(input logic [15:0] d, input int len, input bit fill,
                            input bit low, input bit msb, input bit e);
    rec_t r;
    int   l = 8 * (len + 1);
    for (int k = 0; k < l; k++) begin
      r.v = 1'b1;
      r.d = sent_bit(d, len, fill, low, msb, k);
      r.wr = ((k % 8) == 7);
      r.addr = r.wr ? m_ptr : 0;
      r.dat = r.wr ? group_val(d, len, fill, low, msb, k / 8) : 8'h00;
      if (r.wr) m_ptr = (m_ptr + 1) % 256;
      exp_q.push_back(r);
    end
    if (e) begin
      m_done = 1'b1;
      if (m_ptr != 0) begin
        for (int a = m_ptr; a < 256; a++) begin
          r.v = 1'b0; r.d = 1'b0; r.wr = 1'b1; r.addr = a; r.dat = FILL_V;
          exp_q.push_back(r);
        end
      end
      m_ptr = 0;
    end
  endtask

  // Compare process: check this cycle's outputs, then model acceptance
  always @(negedge clk) begin : compare
    rec_t r;
    bit   have, exp_ready, exp_fin;
    if (reset) begin
      exp_q.delete();
      m_ptr = 0;
      m_done = 1'b0;
      chk("rst_so_valid", bus.so_valid, 0);
      chk("rst_pixel_wr", bus.pixel_wr, 0);
      chk("rst_finish", bus.pixel_finish, 0);
      chk("rst_ready", bus.pi_ready, 1);
    end else begin
      have = (exp_q.size() != 0);
      if (have) r = exp_q.pop_front();
      else r = '{v: 1'b0, d: 1'b0, wr: 1'b0, addr: 0, dat: 8'h00};
      exp_ready = !have && !m_done;
      exp_fin = !have && m_done;
      chk("so_valid", bus.so_valid, r.v);
      if (r.v) chk("so_data", bus.so_data, r.d);
      chk("pixel_wr", bus.pixel_wr, r.wr);
      if (r.wr) chk("pixel_addr", bus.pixel_addr, r.addr);
      chk("pixel_dataout", bus.pixel_dataout, r.dat);
      chk("pixel_finish", bus.pixel_finish, exp_fin);
      chk("pi_ready", bus.pi_ready, exp_ready);
      if (bus.pixel_wr) wlog.push_back({bus.pixel_addr, bus.pixel_dataout});
      if (bus.load && exp_ready)
        push_frame(bus.pi_data, int'(bus.pi_length), bus.pi_fill, bus.pi_low, bus.pi_msb, bus.pi_end);
    end
  end

  task automatic send(input logic [15:0] d, input logic [1:0] len, input bit fill,
                      input bit low, input bit msb, input bit e);
    int n = 0;
    while (!bus.pi_ready && n < 200) begin
      if (noise_en) begin
        bus.load = 1'($urandom); bus.pi_data = 16'($urandom); bus.pi_end = 1'($urandom);
      end else begin
        bus.load = 1'b0;
      end
      @(posedge clk); #2;
      n++;
    end
    if (!bus.pi_ready) chk("ready_timeout", bus.pi_ready, 1);
    bus.load = 1'b1; bus.pi_data = d; bus.pi_length = len; bus.pi_fill = fill;
    bus.pi_low = low; bus.pi_msb = msb; bus.pi_end = e;
    @(posedge clk); #2;
    bus.load = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.pi_ready && n < 200) begin @(posedge clk); #2; n++; end
    if (!bus.pi_ready) chk("ready_timeout", bus.pi_ready, 1);
  endtask

  task automatic wait_finish();
    int n = 0;
    while (!bus.pixel_finish && n < 2500) begin @(posedge clk); #2; n++; end
    chk("finish_reached", bus.pixel_finish, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.load = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    wlog.delete();
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; noise_en = 1'b0;
    bus.load = 1'b0; bus.pi_data = 16'h0000; bus.pi_length = 2'd0; bus.pi_fill = 1'b0;
    bus.pi_low = 1'b0; bus.pi_msb = 1'b0; bus.pi_end = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ready", bus.pi_ready, 1);
    chk("reset_addr", bus.pixel_addr, 0);
    chk("reset_dout", bus.pixel_dataout, 0);
    chk("reset_so_data", bus.so_data, 0);

    // Pin the model to hand-computed pixels
    chk("model_a55a", group_val(16'hA55A, 0, 0, 0, 1, 0), 8'h5A);
    chk("model_f012", group_val(16'hF012, 0, 0, 1, 0, 0), 8'h0F);
    chk("model_1234_g0", group_val(16'h1234, 2, 1, 0, 1, 0), 8'h12);
    chk("model_1234_g1", group_val(16'h1234, 2, 1, 0, 1, 1), 8'h34);
    chk("model_beef_g0", group_val(16'hBEEF, 3, 0, 0, 0, 0), 8'hF7);
    chk("model_beef_g1", group_val(16'hBEEF, 3, 0, 0, 0, 1), 8'h7D);
    chk("model_beef_g3", group_val(16'hBEEF, 3, 0, 0, 0, 3), 8'h00);

    reset = 1'b0;
    wlog.delete();

    // Directed frames
    send(16'hA55A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0); wait_ready();
    chk("t1_wr", wlog[0], 16'h005A);
    send(16'hF012, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0); wait_ready();
    chk("t2_wr", wlog[1], 16'h010F);
    send(16'h1234, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0); wait_ready();
    chk("t3_wr0", wlog[2], 16'h0212);
    chk("t3_wr1", wlog[3], 16'h0334);
    chk("t3_wr2", wlog[4], 16'h0400);
    send(16'hBEEF, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0); wait_ready();
    chk("t4_wr0", wlog[5], 16'h05F7);
    chk("t4_wr1", wlog[6], 16'h067D);
    chk("t4_wr3", wlog[8], 16'h0800);
    chk("t4_count", wlog.size(), 9);

    // Randomised frames with noise on load while busy
    noise_en = 1'b1;
    repeat (150) begin
      send(16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
    end
    noise_en = 1'b0;
    wait_ready();

    // Reset at bit 5 of a 16-bit frame, with a simultaneous load
    send(16'h9C3A, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    chk("mid_valid_before", bus.so_valid, 1);
    reset = 1'b1; bus.load = 1'b1; bus.pi_data = 16'hFFFF;
    #1;
    chk("mid_rst_valid", bus.so_valid, 0);
    chk("mid_rst_ready", bus.pi_ready, 1);
    chk("mid_rst_addr", bus.pixel_addr, 0);
    chk("mid_rst_data", bus.so_data, 0);
    @(posedge clk); #2;
    bus.load = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    wlog.delete();
    @(posedge clk); #2;
    chk("mid_load_dropped", bus.so_valid, 0);
    send(16'h00FF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0); wait_ready();
    chk("mid_next_addr0", wlog[0], 16'h00FF);

    // End-of-stream padding after four 8-bit frames
    do_reset();
    for (int i = 0; i < 4; i++)
      send(16'($urandom), 2'd0, 1'b0, 1'($urandom), 1'($urandom), (i == 3));
    wait_finish();
    chk("pad_count", wlog.size(), 256);
    chk("pad_first", wlog[4], {8'd4, FILL_V});
    chk("pad_last", wlog[255], {8'd255, FILL_V});
    bus.load = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
      chk("done_ready", bus.pi_ready, 0);
      chk("done_valid", bus.so_valid, 0);
    end
    bus.load = 1'b0;

    // End frame whose last write is the top address: no padding
    do_reset();
    for (int i = 0; i < 64; i++)
      send(16'($urandom), 2'd3, 1'($urandom), 1'($urandom), 1'($urandom), (i == 63));
    wait_finish();
    chk("wrap_count", wlog.size(), 256);
    chk("wrap_last_addr", wlog[255][15:8], 8'd255);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
